// File: rtl/vita_tx_control_if.sv
// Sample FIFO handshake between vita_tx_deframer (master) and vita_tx_control (slave).
// Word layout: {send_at, sob, eob, eop, time[63:0], sample[WIDTH-1:0]}.
interface vita_tx_control_if #(
   parameter int WIDTH = 32
);
   logic [4+64+WIDTH-1:0] sample_fifo_i;
   logic                  sample_fifo_src_rdy_i;
   logic                  sample_fifo_dst_rdy_o;

   modport master (
      output sample_fifo_i,
      output sample_fifo_src_rdy_i,
      input  sample_fifo_dst_rdy_o
   );

   modport slave (
      input  sample_fifo_i,
      input  sample_fifo_src_rdy_i,
      output sample_fifo_dst_rdy_o
   );
endinterface

// File: rtl/vita_tx_control.sv
// TX burst controller: holds timed bursts until their start time, feeds one sample per DSP
// strobe, and reports ACK / UNDERRUN / LATE events with the VITA time of the event.
module vita_tx_control #(
   parameter int BASE  = 0,
   parameter int WIDTH = 32
) (
   input  logic                 clk,
   input  logic                 reset,
   input  logic                 clear,
   input  logic                 set_stb,
   input  logic [7:0]           set_addr,
   input  logic [31:0]          set_data,
   input  logic [63:0]          vita_time,
   vita_tx_control_if.slave     fifo,
   output logic [WIDTH-1:0]     sample,
   output logic                 run,
   input  logic                 strobe,
   output logic                 status_stb,
   output logic [1:0]           status_code,
   output logic [63:0]          status_time,
   output logic [31:0]          debug
);

   localparam logic [1:0] CODE_ACK      = 2'd0;
   localparam logic [1:0] CODE_UNDERRUN = 2'd1;
   localparam logic [1:0] CODE_LATE     = 2'd2;

   typedef enum logic [2:0] {
      IDLE      = 3'd0,
      WAIT_TIME = 3'd1,
      RUN       = 3'd2,
      DRAIN     = 3'd3
   } state_t;

   state_t      state;
   logic [1:0]  policy;
   logic        last_eop;
   logic        last_eob;

   logic             src_rdy;
   logic             dst_rdy;
   logic             hd_send_at;
   logic             hd_sob;
   logic             hd_eob;
   logic             hd_eop;
   logic [63:0]      hd_time;
   logic [WIDTH-1:0] hd_sample;
   logic             unused_bits;

   // A word ends the discard region on eob when policy bit0 is set, else on eop.
   function automatic logic at_boundary(input logic pol0, input logic eob, input logic eop);
      return pol0 ? eob : eop;
   endfunction

   assign src_rdy = fifo.sample_fifo_src_rdy_i;
   assign {hd_send_at, hd_sob, hd_eob, hd_eop, hd_time, hd_sample} = fifo.sample_fifo_i;
   assign unused_bits = ^{hd_sob, set_data[31:2]};

   assign run     = (state == RUN);
   assign sample  = (run && src_rdy) ? hd_sample : '0;
   assign dst_rdy = (run && strobe && src_rdy) || ((state == DRAIN) && src_rdy);
   assign fifo.sample_fifo_dst_rdy_o = dst_rdy;
   assign debug   = {state, policy, src_rdy, dst_rdy, strobe, 24'd0};

   always_ff @(posedge clk) begin
      if (!reset || clear) begin
         state       <= IDLE;
         policy      <= 2'd0;
         last_eop    <= 1'b0;
         last_eob    <= 1'b0;
         status_stb  <= 1'b0;
         status_code <= CODE_ACK;
         status_time <= 64'd0;
      end else begin
         if (set_stb && (set_addr == 8'(BASE)))
            policy <= set_data[1:0];
         status_stb <= 1'b0;
         case (state)
            // Holding off while an event is still being reported keeps status_stb single-cycle.
            IDLE: begin
               if (src_rdy && !status_stb) begin
                  last_eop <= 1'b0;
                  last_eob <= 1'b0;
                  if (!hd_send_at) begin
                     state <= RUN;
                  end else if (hd_time > vita_time) begin
                     state <= WAIT_TIME;
                  end else begin
                     state       <= DRAIN;
                     status_stb  <= 1'b1;
                     status_code <= CODE_LATE;
                     status_time <= vita_time;
                  end
               end
            end
            WAIT_TIME: begin
               if (vita_time == hd_time)
                  state <= RUN;
            end
            RUN: begin
               if (strobe && src_rdy) begin
                  last_eop <= hd_eop;
                  last_eob <= hd_eob;
                  if (hd_eob) begin
                     state       <= IDLE;
                     status_stb  <= 1'b1;
                     status_code <= CODE_ACK;
                     status_time <= vita_time;
                  end
               end else if (strobe) begin
                  // Nothing left to discard if the last word already closed the region.
                  state       <= at_boundary(policy[0], last_eob, last_eop) ? IDLE : DRAIN;
                  status_stb  <= 1'b1;
                  status_code <= CODE_UNDERRUN;
                  status_time <= vita_time;
               end
            end
            DRAIN: begin
               if (src_rdy && at_boundary(policy[0], hd_eob, hd_eop))
                  state <= IDLE;
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule
